pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator. Measures an incoming, asynchronous PWM waveform in clk cycles.
- Reports high time (duty) and rise-to-rise period, using the same counting convention as the generator, so a looped-back generator programmed with duty_cnt=D, period_cnt=P reads back D and P.
- Sits behind the AXI-Lite register block. start/stop arrive as single-cycle clk-domain pulses.

Parameters:
- C_COUNTER_WIDTH, 32, width of period/duty counters and outputs
- C_SYNC_STAGES, 2, synchronizer flops on pwm_in (range 2-4)
- C_TIMEOUT_CNT, 32'h00FF_FFFF, edge-less cycles before timeout (used only with PWM_CAPTURE_TIMEOUT_EN)

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: arm/re-arm capture, clear overflow
- stop  in  1  one-cycle pulse: stop capture, hold last results
- pwm_in  in  1  asynchronous PWM input
- period_cnt  out  C_COUNTER_WIDTH  last measured period (cycles)
- duty_cnt  out  C_COUNTER_WIDTH  last measured high time (cycles)
- valid  out  1  one-cycle pulse when period_cnt/duty_cnt update
- busy  out  1  high in any state except IDLE
- overflow  out  1  sticky: a counter saturated
- timeout  out  1  one-cycle pulse on edge timeout (tied 0 without macro)

Behaviour:
- Reset: state IDLE; period_cnt, duty_cnt, internal counters = 0; valid, busy, overflow, timeout = 0; synchronizer and edge flops = 0.
- Input path: C_SYNC_STAGES flops, then one edge-detect flop. Rise/fall is detected C_SYNC_STAGES+1 cycles after the input edge. The latency is identical for both edges, so it cancels in all measurements.
- States:
  - IDLE: ignores edges. start -> ARM.
  - ARM: waits for a rise. A rise sets per_cnt=1, high_cnt=1 and moves to HIGH. No report is made on this first rise.
  - HIGH: per_cnt++ and high_cnt++ every cycle. On a fall cycle: per_cnt++, high_cnt holds, move to LOW.
  - LOW: per_cnt++ every cycle. On a rise cycle: period_cnt<=per_cnt, duty_cnt<=high_cnt, valid=1 for that cycle, per_cnt=1, high_cnt=1, move to HIGH.
  - The rise cycle counts as cycle 1 of the new period.
- Arithmetic: counters saturate at all-ones and never wrap. The first saturation sets overflow. Saturated values are still reported.
- stop (any state): IDLE next cycle, outputs held, no valid.
- start while busy: ARM next cycle, counters zeroed, overflow cleared, outputs held.
- start and stop in the same cycle: stop wins.
- Reset mid-operation: full reset values immediately on the next edge; no valid.
- Constant input (0% or 100% duty): no report. Counters saturate and overflow sets; timeout applies only with the macro.
- Minimum measurable: high >= 1 and low >= 1 cycle after synchronization. A pulse narrower than one clk may be missed; this is acceptable.

Optional Feature:
- Macro PWM_CAPTURE_TIMEOUT_EN.
- Defined: an idle counter clears on every edge and increments in ARM/HIGH/LOW. On reaching C_TIMEOUT_CNT: timeout pulses 1 cycle; duty_cnt<=0 if the input is low, otherwise duty_cnt<=all-ones; period_cnt<=0; valid pulses; state -> ARM.
- Undefined: no idle counter; timeout tied 0; stuck input only saturates and sets overflow.

Decomposition:
- Package pwm_capture_pkg holds:
  - state enum (IDLE, ARM, HIGH, LOW)
  - saturating-increment function
  - default width/timeout constants
- One sub-module, pwm_sync_edge: C_SYNC_STAGES synchronizer plus edge flop. Outputs level, rise, fall. Resets synchronously to 0.

Test Plan:
- Loopback from the PWM generator with duty_cnt=3, period_cnt=10, then start -> first valid at the second rise; period_cnt=10, duty_cnt=3; repeats every 10 cycles.
- Change to duty 7 / period 20 mid-run -> at most one mixed report, then 20/7 steady; overflow stays 0.
- Stimulus pwm_in stuck high with C_COUNTER_WIDTH=8 -> no valid; overflow=1 after 255 cycles; a later start clears overflow.
- stop issued in LOW, followed by more edges -> no valid; outputs hold the last values; busy=0 next cycle.
- reset asserted in HIGH -> next cycle all outputs 0, state IDLE; edges ignored until start.
- With PWM_CAPTURE_TIMEOUT_EN and C_TIMEOUT_CNT=50, pwm_in held low -> timeout and valid pulse at idle-cycle 50; duty_cnt=0; period_cnt=0; state ARM.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared types and helpers for the PWM capture block.
package pwm_capture_pkg;

    localparam int unsigned C_DEF_COUNTER_WIDTH = 32;
    localparam int unsigned C_DEF_SYNC_STAGES   = 2;
    localparam int unsigned C_DEF_TIMEOUT_CNT   = 32'h00FF_FFFF;
    localparam int unsigned C_MAX_WIDTH         = 64;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } state_t;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [C_MAX_WIDTH-1:0] sat_inc(
        input logic [C_MAX_WIDTH-1:0] val,
        input logic [C_MAX_WIDTH-1:0] max_val
    );
        if (val >= max_val) begin
            return max_val;
        end
        return val + C_MAX_WIDTH'(1);
    endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchronizer chain on the async PWM input followed by one edge-detect flop.
module pwm_sync_edge #(
    parameter int unsigned C_SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [C_SYNC_STAGES-1:0] sync_q;
    logic                     edge_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[C_SYNC_STAGES-2:0], pwm_in};
            edge_q <= sync_q[C_SYNC_STAGES-1];
        end
    end

    assign level = sync_q[C_SYNC_STAGES-1];
    assign rise  = level & ~edge_q;
    assign fall  = ~level & edge_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an async PWM input in clk cycles.
// Optional edge timeout enabled by defining PWM_CAPTURE_TIMEOUT_EN.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned C_COUNTER_WIDTH = C_DEF_COUNTER_WIDTH,
    parameter int unsigned C_SYNC_STAGES   = C_DEF_SYNC_STAGES,
    parameter int unsigned C_TIMEOUT_CNT   = C_DEF_TIMEOUT_CNT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       pwm_in,
    output logic [C_COUNTER_WIDTH-1:0] period_cnt,
    output logic [C_COUNTER_WIDTH-1:0] duty_cnt,
    output logic                       valid,
    output logic                       busy,
    output logic                       overflow,
    output logic                       timeout
);

    localparam logic [C_COUNTER_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [C_COUNTER_WIDTH-1:0] CNT_ONE = C_COUNTER_WIDTH'(1);

    state_t                     state, state_nxt;
    logic [C_COUNTER_WIDTH-1:0] per_cnt, per_nxt, per_inc;
    logic [C_COUNTER_WIDTH-1:0] high_cnt, high_nxt, high_inc;
    logic [C_COUNTER_WIDTH-1:0] period_nxt, duty_nxt;
    logic                       valid_nxt, busy_nxt, ovf_nxt, timeout_nxt;
    logic                       level, rise, fall;
    logic                       to_hit;

    pwm_sync_edge #(
        .C_SYNC_STAGES(C_SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .reset (reset),
        .pwm_in(pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign per_inc  = C_COUNTER_WIDTH'(sat_inc(C_MAX_WIDTH'(per_cnt), C_MAX_WIDTH'(CNT_MAX)));
    assign high_inc = C_COUNTER_WIDTH'(sat_inc(C_MAX_WIDTH'(high_cnt), C_MAX_WIDTH'(CNT_MAX)));

`ifdef PWM_CAPTURE_TIMEOUT_EN
    // Idle counter: cycles since the last edge while capture is active.
    logic [31:0] idle_cnt, idle_nxt;

    always_comb begin
        idle_nxt = '0;
        to_hit   = 1'b0;
        if (state != IDLE && !rise && !fall) begin
            idle_nxt = idle_cnt + 32'd1;
            to_hit   = (idle_nxt == 32'(C_TIMEOUT_CNT));
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start || stop || to_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_nxt;
        end
    end
`else
    logic unused_timeout;
    assign to_hit         = 1'b0;
    assign unused_timeout = ^C_TIMEOUT_CNT;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            per_cnt    <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            duty_cnt   <= '0;
            valid      <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            per_cnt    <= per_nxt;
            high_cnt   <= high_nxt;
            period_cnt <= period_nxt;
            duty_cnt   <= duty_nxt;
            valid      <= valid_nxt;
            busy       <= busy_nxt;
            overflow   <= ovf_nxt;
            timeout    <= timeout_nxt;
        end
    end

    // stop beats start, start beats timeout, timeout beats edges.
    always_comb begin
        state_nxt   = state;
        per_nxt     = per_cnt;
        high_nxt    = high_cnt;
        period_nxt  = period_cnt;
        duty_nxt    = duty_cnt;
        valid_nxt   = 1'b0;
        ovf_nxt     = overflow;
        timeout_nxt = 1'b0;

        if (stop) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = ARM;
            per_nxt   = '0;
            high_nxt  = '0;
            ovf_nxt   = 1'b0;
        end else if (to_hit) begin
            state_nxt   = ARM;
            per_nxt     = '0;
            high_nxt    = '0;
            period_nxt  = '0;
            duty_nxt    = level ? CNT_MAX : '0;
            valid_nxt   = 1'b1;
            timeout_nxt = 1'b1;
        end else begin
            case (state)
                ARM: begin
                    if (rise) begin
                        per_nxt   = CNT_ONE;
                        high_nxt  = CNT_ONE;
                        state_nxt = HIGH;
                    end
                end
                HIGH: begin
                    per_nxt = per_inc;
                    if (per_inc == CNT_MAX) begin
                        ovf_nxt = 1'b1;
                    end
                    if (fall) begin
                        state_nxt = LOW;
                    end else begin
                        high_nxt = high_inc;
                        if (high_inc == CNT_MAX) begin
                            ovf_nxt = 1'b1;
                        end
                    end
                end
                LOW: begin
                    if (rise) begin
                        period_nxt = per_cnt;
                        duty_nxt   = high_cnt;
                        valid_nxt  = 1'b1;
                        per_nxt    = CNT_ONE;
                        high_nxt   = CNT_ONE;
                        state_nxt  = HIGH;
                    end else begin
                        per_nxt = per_inc;
                        if (per_inc == CNT_MAX) begin
                            ovf_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture with a behavioural PWM source.
module tb_pwm_capture;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset, start, stop, pwm_in;
    logic [W-1:0] period_cnt, duty_cnt;
    logic         valid, busy, overflow, timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural PWM generator: high for g_d cycles out of every g_p.
    int   g_d, g_p, g_ctr;
    bit   gen_on;
    logic man_lvl;

    typedef struct {
        int d;
        int p;
        int exp_d;
        int exp_p;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    pwm_capture #(
        .C_COUNTER_WIDTH(W),
        .C_SYNC_STAGES  (2),
        .C_TIMEOUT_CNT  (50)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .pwm_in    (pwm_in),
        .period_cnt(period_cnt),
        .duty_cnt  (duty_cnt),
        .valid     (valid),
        .busy      (busy),
        .overflow  (overflow),
        .timeout   (timeout)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are read #1 after the edge, then pwm_in is driven.
    task automatic tick();
        @(posedge clk);
        #1;
        if (gen_on) begin
            pwm_in = (g_ctr < g_d);
            g_ctr  = (g_ctr + 1 >= g_p) ? 0 : g_ctr + 1;
        end else begin
            pwm_in = man_lvl;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic flush_low();
        gen_on  = 1'b0;
        man_lvl = 1'b0;
        repeat (6) tick();
    endtask

    task automatic set_gen(input int d, input int p);
        g_d    = d;
        g_p    = p;
        g_ctr  = 0;
        gen_on = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int k = 0;
        while (!valid && k < max_cyc) begin
            tick();
            k++;
        end
        check({name, "_valid_seen"}, int'(valid), 1);
    endtask

    task automatic run_collect(input string name, input int n, input int exp_p,
                               input int exp_d, output int nv);
        nv = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (valid) begin
                nv++;
                check({name, "_period"}, int'(period_cnt), exp_p);
                check({name, "_duty"}, int'(duty_cnt), exp_d);
            end
        end
    endtask

    initial begin
        int lat;
        int nv;
        int mixed;
        int last_p;
        int last_d;
        int any_to;

        vecs[0] = '{d: 3,  p: 10, exp_d: 3,  exp_p: 10};
        vecs[1] = '{d: 1,  p: 2,  exp_d: 1,  exp_p: 2};
        vecs[2] = '{d: 5,  p: 6,  exp_d: 5,  exp_p: 6};
        vecs[3] = '{d: 1,  p: 9,  exp_d: 1,  exp_p: 9};
        vecs[4] = '{d: 8,  p: 9,  exp_d: 8,  exp_p: 9};
        vecs[5] = '{d: 20, p: 25, exp_d: 20, exp_p: 25};

        reset   = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        pwm_in  = 1'b0;
        man_lvl = 1'b0;
        gen_on  = 1'b0;
        g_d     = 0;
        g_p     = 1;
        g_ctr   = 0;
        repeat (3) tick();
        check("rst_period", int'(period_cnt), 0);
        check("rst_duty", int'(duty_cnt), 0);
        check("rst_flags", int'({valid, busy, overflow, timeout}), 0);
        reset = 1'b0;
        tick();

        // First report lands at the second rise: P + sync stages + edge flop.
        pulse_start();
        check("arm_busy", int'(busy), 1);
        set_gen(3, 10);
        tick();
        lat = 0;
        while (!valid && lat < 40) begin
            tick();
            lat++;
        end
        check("first_latency", lat, 13);
        check("first_period", int'(period_cnt), 10);
        check("first_duty", int'(duty_cnt), 3);
        run_collect("steady_10_3", 45, 10, 3, nv);
        check("steady_10_3_count", nv, 4);

        // Switch to 7/20 at a period boundary without re-arming.
        lat = 0;
        while (g_ctr != 0 && lat < 20) begin
            tick();
            lat++;
        end
        g_d    = 7;
        g_p    = 20;
        mixed  = 0;
        nv     = 0;
        last_p = 0;
        last_d = 0;
        for (int i = 0; i < 170; i++) begin
            tick();
            if (valid) begin
                nv++;
                last_p = int'(period_cnt);
                last_d = int'(duty_cnt);
                if (!((last_p == 10 && last_d == 3) || (last_p == 20 && last_d == 7))) begin
                    mixed++;
                end
            end
        end
        check("change_mixed_le1", int'(mixed <= 1), 1);
        check("change_count_ge7", int'(nv >= 7), 1);
        check("change_last_period", last_p, 20);
        check("change_last_duty", last_d, 7);
        check("change_overflow", int'(overflow), 0);

        // Table of loopback settings; each re-arms with start while busy.
        foreach (vecs[i]) begin
            flush_low();
            pulse_start();
            check($sformatf("vec%0d_busy", i), int'(busy), 1);
            set_gen(vecs[i].d, vecs[i].p);
            run_collect($sformatf("vec%0d", i), 3 * vecs[i].p + 20,
                        vecs[i].exp_p, vecs[i].exp_d, nv);
            check($sformatf("vec%0d_count_ge2", i), int'(nv >= 2), 1);
            check($sformatf("vec%0d_overflow", i), int'(overflow), 0);
        end

        // stop while in LOW: no further reports, results held.
        flush_low();
        pulse_start();
        set_gen(3, 10);
        wait_valid("stop", 40);
        repeat (5) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_busy", int'(busy), 0);
        run_collect("stop_hold", 40, 10, 3, nv);
        check("stop_no_valid", nv, 0);
        check("stop_period_held", int'(period_cnt), 10);
        check("stop_duty_held", int'(duty_cnt), 3);

        // Reset in HIGH clears everything; edges ignored until start.
        pulse_start();
        wait_valid("rst_mid", 40);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_period", int'(period_cnt), 0);
        check("rstmid_duty", int'(duty_cnt), 0);
        check("rstmid_flags", int'({valid, busy, overflow, timeout}), 0);
        run_collect("rstmid_idle", 30, 0, 0, nv);
        check("rstmid_no_valid", nv, 0);
        check("rstmid_busy", int'(busy), 0);
        pulse_start();
        wait_valid("rstmid_restart", 40);
        check("rstmid_restart_period", int'(period_cnt), 10);
        check("rstmid_restart_duty", int'(duty_cnt), 3);

`ifndef PWM_CAPTURE_TIMEOUT_EN
        // Stuck-high input: counters saturate, overflow sticks, no report.
        flush_low();
        pulse_start();
        man_lvl = 1'b1;
        any_to  = 0;
        nv      = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (valid) nv++;
            if (timeout) any_to++;
        end
        check("stuck_ovf_early", int'(overflow), 0);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (valid) nv++;
            if (timeout) any_to++;
        end
        check("stuck_ovf_set", int'(overflow), 1);
        check("stuck_no_valid", nv, 0);
        check("stuck_no_timeout", any_to, 0);
        check("stuck_period_held", int'(period_cnt), 10);
        pulse_start();
        check("stuck_start_clears_ovf", int'(overflow), 0);
        check("stuck_start_busy", int'(busy), 1);
`else
        // Held-low input: timeout after 50 edge-less cycles, re-armed.
        flush_low();
        pulse_start();
        lat = 0;
        while (!timeout && lat < 100) begin
            tick();
            lat++;
        end
        check("to_latency", lat, 50);
        check("to_valid", int'(valid), 1);
        check("to_duty", int'(duty_cnt), 0);
        check("to_period", int'(period_cnt), 0);
        check("to_busy", int'(busy), 1);
        tick();
        check("to_pulse_one_cycle", int'(timeout), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
